// File: rtl/instruction_decode_stage_pkg.sv
// Shared types and constants for the RV32I decode stage: opcodes, control
// encodings and the ID/EX pipeline record.
package instruction_decode_stage_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_src_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_t;

   typedef struct packed {
      logic              reg_write;
      result_src_t       result_src;
      logic              mem_write;
      logic              jump;
      logic              branch;
      logic              alu_src;
      alu_ctrl_t         alu_ctrl;
      logic              illegal;
      logic [XLEN-1:0]   rd1;
      logic [XLEN-1:0]   rd2;
      logic [XLEN-1:0]   imm_ext;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [4:0]        rd;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   pc_plus4;
   } id_ex_t;

endpackage

// File: rtl/instruction_decode_stage_if.sv
// Bundle of fetch inputs, hazard/writeback controls and execute-stage outputs
// of the decode stage.
interface instruction_decode_stage_if;
   import instruction_decode_stage_pkg::*;

   logic [XLEN-1:0] InstrF;
   logic [XLEN-1:0] PCF;
   logic [XLEN-1:0] PCPlus4F;
   logic            StallD;
   logic            FlushD;
   logic            FlushE;
   logic            RegWriteW;
   logic [4:0]      RdW;
   logic [XLEN-1:0] ResultW;
   logic [4:0]      Rs1D;
   logic [4:0]      Rs2D;
   logic            RegWriteE;
   logic [1:0]      ResultSrcE;
   logic            MemWriteE;
   logic            JumpE;
   logic            BranchE;
   logic            ALUSrcE;
   logic [2:0]      ALUControlE;
   logic            IllegalE;
   logic [XLEN-1:0] RD1E;
   logic [XLEN-1:0] RD2E;
   logic [XLEN-1:0] ImmExtE;
   logic [4:0]      Rs1E;
   logic [4:0]      Rs2E;
   logic [4:0]      RdE;
   logic [XLEN-1:0] PCE;
   logic [XLEN-1:0] PCPlus4E;

   modport master (
      output InstrF, PCF, PCPlus4F, StallD, FlushD, FlushE, RegWriteW, RdW, ResultW,
      input  Rs1D, Rs2D, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
             ALUControlE, IllegalE, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E
   );

   modport slave (
      input  InstrF, PCF, PCPlus4F, StallD, FlushD, FlushE, RegWriteW, RdW, ResultW,
      output Rs1D, Rs2D, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE,
             ALUControlE, IllegalE, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E
   );

endinterface

// File: rtl/instruction_decode_stage_register_file.sv
// 32x32 register file, two async read ports and one posedge write port, with
// same-cycle writeback bypass; x0 is hardwired to zero.
module instruction_decode_stage_register_file
   import instruction_decode_stage_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [4:0]      raddr1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   logic [XLEN-1:0] regs_r [1:31];

   // Storage for x1..x31; writes to x0 never reach the array.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < 32; i++) begin
            regs_r[i] <= 32'h0000_0000;
         end
      end else if (we && (waddr != 5'd0)) begin
         regs_r[waddr] <= wdata;
      end
   end

   // Read port 1 with writeback bypass.
   always_comb begin
      if (raddr1 == 5'd0) begin
         rdata1 = 32'h0000_0000;
      end else if (we && (waddr == raddr1)) begin
         rdata1 = wdata;
      end else begin
         rdata1 = regs_r[raddr1];
      end
   end

   // Read port 2 with writeback bypass.
   always_comb begin
      if (raddr2 == 5'd0) begin
         rdata2 = 32'h0000_0000;
      end else if (we && (waddr == raddr2)) begin
         rdata2 = wdata;
      end else begin
         rdata2 = regs_r[raddr2];
      end
   end

endmodule

// File: rtl/instruction_decode_stage.sv
// RV32I decode stage: IF/ID register, register file, control and immediate
// decode, and the ID/EX register feeding execute and the hazard unit.
module instruction_decode_stage
   import instruction_decode_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   instruction_decode_stage_if.slave  bus
);

   logic [XLEN-1:0] instr_d_r;
   logic [XLEN-1:0] pc_d_r;
   logic [XLEN-1:0] pc_plus4_d_r;

   logic [6:0]      opcode_s;
   logic [2:0]      funct3_s;
   logic [4:0]      rs1_s;
   logic [4:0]      rs2_s;
   logic [4:0]      rd_s;
   logic [XLEN-1:0] rd1_s;
   logic [XLEN-1:0] rd2_s;

   logic            reg_write_s;
   imm_src_t        imm_src_s;
   logic            alu_src_s;
   logic            mem_write_s;
   result_src_t     result_src_s;
   logic            branch_s;
   logic [1:0]      alu_op_s;
   logic            jump_s;
   logic            illegal_op_s;
   alu_ctrl_t       alu_ctrl_s;
   logic            illegal_f3_s;
   logic [XLEN-1:0] imm_ext_s;

   id_ex_t          id_ex_s;
   id_ex_t          id_ex_r;

   // IF/ID register: flush beats stall, stall holds the current contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_d_r    <= NOP_INSTR;
         pc_d_r       <= 32'h0000_0000;
         pc_plus4_d_r <= 32'h0000_0000;
      end else if (bus.FlushD) begin
         instr_d_r    <= NOP_INSTR;
         pc_d_r       <= 32'h0000_0000;
         pc_plus4_d_r <= 32'h0000_0000;
      end else if (!bus.StallD) begin
         instr_d_r    <= bus.InstrF;
         pc_d_r       <= bus.PCF;
         pc_plus4_d_r <= bus.PCPlus4F;
      end
   end

   assign opcode_s = instr_d_r[6:0];
   assign rd_s     = instr_d_r[11:7];
   assign funct3_s = instr_d_r[14:12];
   assign rs1_s    = instr_d_r[19:15];
   assign rs2_s    = instr_d_r[24:20];

   assign bus.Rs1D = rs1_s;
   assign bus.Rs2D = rs2_s;

   instruction_decode_stage_register_file u_register_file (
      .clk    (clk),
      .rst    (rst),
      .we     (bus.RegWriteW),
      .waddr  (bus.RdW),
      .wdata  (bus.ResultW),
      .raddr1 (rs1_s),
      .raddr2 (rs2_s),
      .rdata1 (rd1_s),
      .rdata2 (rd2_s)
   );

   // Main decoder; don't-care fields are driven as zero.
   always_comb begin
      reg_write_s  = 1'b0;
      imm_src_s    = IMM_I;
      alu_src_s    = 1'b0;
      mem_write_s  = 1'b0;
      result_src_s = RES_ALU;
      branch_s     = 1'b0;
      alu_op_s     = 2'b00;
      jump_s       = 1'b0;
      illegal_op_s = 1'b0;
      case (opcode_s)
         OP_LOAD: begin
            reg_write_s  = 1'b1;
            alu_src_s    = 1'b1;
            result_src_s = RES_MEM;
         end
         OP_STORE: begin
            imm_src_s   = IMM_S;
            alu_src_s   = 1'b1;
            mem_write_s = 1'b1;
         end
         OP_RTYPE: begin
            reg_write_s = 1'b1;
            alu_op_s    = 2'b10;
         end
         OP_BRANCH: begin
            imm_src_s = IMM_B;
            branch_s  = 1'b1;
            alu_op_s  = 2'b01;
         end
         OP_IALU: begin
            reg_write_s = 1'b1;
            alu_src_s   = 1'b1;
            alu_op_s    = 2'b10;
         end
         OP_JAL: begin
            reg_write_s  = 1'b1;
            imm_src_s    = IMM_J;
            result_src_s = RES_PC4;
            jump_s       = 1'b1;
         end
         default: begin
            illegal_op_s = 1'b1;
         end
      endcase
   end

   // ALU decoder; subtract only for R-type with funct7[5] set.
   always_comb begin
      alu_ctrl_s   = ALU_ADD;
      illegal_f3_s = 1'b0;
      case (alu_op_s)
         2'b00: alu_ctrl_s = ALU_ADD;
         2'b01: alu_ctrl_s = ALU_SUB;
         2'b10: begin
            case (funct3_s)
               3'b000: begin
                  if (instr_d_r[5] && instr_d_r[30]) begin
                     alu_ctrl_s = ALU_SUB;
                  end else begin
                     alu_ctrl_s = ALU_ADD;
                  end
               end
               3'b010:  alu_ctrl_s = ALU_SLT;
               3'b110:  alu_ctrl_s = ALU_OR;
               3'b111:  alu_ctrl_s = ALU_AND;
               default: begin
                  alu_ctrl_s   = ALU_ADD;
                  illegal_f3_s = 1'b1;
               end
            endcase
         end
         default: alu_ctrl_s = ALU_ADD;
      endcase
   end

   // Immediate extender.
   always_comb begin
      imm_ext_s = 32'h0000_0000;
      case (imm_src_s)
         IMM_I:   imm_ext_s = {{20{instr_d_r[31]}}, instr_d_r[31:20]};
         IMM_S:   imm_ext_s = {{20{instr_d_r[31]}}, instr_d_r[31:25], instr_d_r[11:7]};
         IMM_B:   imm_ext_s = {{20{instr_d_r[31]}}, instr_d_r[7], instr_d_r[30:25],
                               instr_d_r[11:8], 1'b0};
         IMM_J:   imm_ext_s = {{12{instr_d_r[31]}}, instr_d_r[19:12], instr_d_r[20],
                               instr_d_r[30:21], 1'b0};
         default: imm_ext_s = 32'h0000_0000;
      endcase
   end

   // Next ID/EX contents.
   always_comb begin
      id_ex_s.reg_write  = reg_write_s;
      id_ex_s.result_src = result_src_s;
      id_ex_s.mem_write  = mem_write_s;
      id_ex_s.jump       = jump_s;
      id_ex_s.branch     = branch_s;
      id_ex_s.alu_src    = alu_src_s;
      id_ex_s.alu_ctrl   = alu_ctrl_s;
      id_ex_s.illegal    = illegal_op_s | illegal_f3_s;
      id_ex_s.rd1        = rd1_s;
      id_ex_s.rd2        = rd2_s;
      id_ex_s.imm_ext    = imm_ext_s;
      id_ex_s.rs1        = rs1_s;
      id_ex_s.rs2        = rs2_s;
      id_ex_s.rd         = rd_s;
      id_ex_s.pc         = pc_d_r;
      id_ex_s.pc_plus4   = pc_plus4_d_r;
   end

   // ID/EX register; a flush inserts an all-zero bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_ex_r <= {$bits(id_ex_t){1'b0}};
      end else if (bus.FlushE) begin
         id_ex_r <= {$bits(id_ex_t){1'b0}};
      end else begin
         id_ex_r <= id_ex_s;
      end
   end

   assign bus.RegWriteE   = id_ex_r.reg_write;
   assign bus.ResultSrcE  = id_ex_r.result_src;
   assign bus.MemWriteE   = id_ex_r.mem_write;
   assign bus.JumpE       = id_ex_r.jump;
   assign bus.BranchE     = id_ex_r.branch;
   assign bus.ALUSrcE     = id_ex_r.alu_src;
   assign bus.ALUControlE = id_ex_r.alu_ctrl;
   assign bus.IllegalE    = id_ex_r.illegal;
   assign bus.RD1E        = id_ex_r.rd1;
   assign bus.RD2E        = id_ex_r.rd2;
   assign bus.ImmExtE     = id_ex_r.imm_ext;
   assign bus.Rs1E        = id_ex_r.rs1;
   assign bus.Rs2E        = id_ex_r.rs2;
   assign bus.RdE         = id_ex_r.rd;
   assign bus.PCE         = id_ex_r.pc;
   assign bus.PCPlus4E    = id_ex_r.pc_plus4;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Scoreboard bench for the decode stage: directed instructions push expected
// field values tagged with the cycle they must appear in; a monitor compares.
module tb_instruction_decode_stage;

   localparam int F_REGWRITE = 0;
   localparam int F_RESSRC   = 1;
   localparam int F_MEMWRITE = 2;
   localparam int F_JUMP     = 3;
   localparam int F_BRANCH   = 4;
   localparam int F_ALUSRC   = 5;
   localparam int F_ALUCTRL  = 6;
   localparam int F_ILLEGAL  = 7;
   localparam int F_RD1      = 8;
   localparam int F_RD2      = 9;
   localparam int F_IMM      = 10;
   localparam int F_RDE      = 11;
   localparam int F_PCE      = 12;
   localparam int F_PC4E     = 13;
   localparam int F_RS1D     = 14;

   localparam logic [31:0] I_NOP  = 32'h0000_0013;
   localparam logic [31:0] I_ADDI = 32'h0070_0293; // addi x5,x0,7
   localparam logic [31:0] I_ADD  = 32'h0062_83B3; // add  x7,x5,x6
   localparam logic [31:0] I_SUB  = 32'h4002_8433; // sub  x8,x5,x0
   localparam logic [31:0] I_OR   = 32'h0002_E4B3; // or   x9,x5,x0
   localparam logic [31:0] I_AND  = 32'h0050_7533; // and  x10,x0,x5
   localparam logic [31:0] I_SLT  = 32'h0000_25B3; // slt  x11,x0,x0
   localparam logic [31:0] I_BEQ  = 32'hFE00_0EE3; // beq  x0,x0,-4
   localparam logic [31:0] I_SW   = 32'h0050_2423; // sw   x5,8(x0)
   localparam logic [31:0] I_LW   = 32'hFFF0_2603; // lw   x12,-1(x0)
   localparam logic [31:0] I_JAL  = 32'h0080_00EF; // jal  x1,8
   localparam logic [31:0] I_BAD  = 32'h0000_007F;
   localparam logic [31:0] I_SLL  = 32'h0000_1033; // sll  x0,x0,x0

   typedef struct {
      int          cyc;
      int          fld;
      logic [31:0] val;
      string       name;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   done = 1'b0;
   exp_t exp_q[$];

   instruction_decode_stage_if bus ();

   instruction_decode_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] field_val(input int f);
      case (f)
         F_REGWRITE: return {31'd0, bus.RegWriteE};
         F_RESSRC:   return {30'd0, bus.ResultSrcE};
         F_MEMWRITE: return {31'd0, bus.MemWriteE};
         F_JUMP:     return {31'd0, bus.JumpE};
         F_BRANCH:   return {31'd0, bus.BranchE};
         F_ALUSRC:   return {31'd0, bus.ALUSrcE};
         F_ALUCTRL:  return {29'd0, bus.ALUControlE};
         F_ILLEGAL:  return {31'd0, bus.IllegalE};
         F_RD1:      return bus.RD1E;
         F_RD2:      return bus.RD2E;
         F_IMM:      return bus.ImmExtE;
         F_RDE:      return {27'd0, bus.RdE};
         F_PCE:      return bus.PCE;
         F_PC4E:     return bus.PCPlus4E;
         F_RS1D:     return {27'd0, bus.Rs1D};
         default:    return 32'hFFFF_FFFF;
      endcase
   endfunction

   task automatic chk(input int t, input int f, input logic [31:0] v, input string n);
      exp_t e;
      e.cyc  = t;
      e.fld  = f;
      e.val  = v;
      e.name = n;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_f(input logic [31:0] ins, input logic [31:0] pc);
      bus.InstrF   = ins;
      bus.PCF      = pc;
      bus.PCPlus4F = pc + 32'd4;
   endtask

   // Monitor: compare every entry due this cycle, away from the active edge.
   initial begin
      logic [31:0] act;
      int          i;
      forever begin
         @(negedge clk);
         i = 0;
         while (i < exp_q.size()) begin
            if (exp_q[i].cyc == cyc) begin
               act = field_val(exp_q[i].fld);
               checks++;
               if (act !== exp_q[i].val) begin
                  errors++;
                  $display("FAIL %s: got %h expected %h (cycle %0d)",
                           exp_q[i].name, act, exp_q[i].val, cyc);
               end
               exp_q.delete(i);
            end else begin
               i++;
            end
         end
         if (done) begin
            foreach (exp_q[k]) begin
               errors++;
               $display("FAIL %s: never compared, expected %h at cycle %0d",
                        exp_q[k].name, exp_q[k].val, exp_q[k].cyc);
            end
            exp_q.delete();
         end
      end
   end

   initial begin
      int c;
      rst           = 1'b1;
      bus.StallD    = 1'b0;
      bus.FlushD    = 1'b0;
      bus.FlushE    = 1'b0;
      bus.RegWriteW = 1'b0;
      bus.RdW       = 5'd0;
      bus.ResultW   = 32'h0;
      drive_f(I_NOP, 32'h0);
      step();
      step();
      chk(cyc, F_REGWRITE, 32'd0, "rst_regwrite");
      chk(cyc, F_ALUSRC,   32'd0, "rst_alusrc");
      chk(cyc, F_PCE,      32'd0, "rst_pce");
      chk(cyc, F_IMM,      32'd0, "rst_imm");
      chk(cyc, F_RS1D,     32'd0, "rst_rs1d");
      step();
      rst = 1'b0;

      c = cyc; drive_f(I_ADDI, 32'h100);
      chk(c + 2, F_REGWRITE, 32'd1,   "addi_regwrite");
      chk(c + 2, F_ALUSRC,   32'd1,   "addi_alusrc");
      chk(c + 2, F_ALUCTRL,  32'd0,   "addi_aluctrl");
      chk(c + 2, F_IMM,      32'd7,   "addi_imm");
      chk(c + 2, F_RDE,      32'd5,   "addi_rde");
      chk(c + 2, F_PCE,      32'h100, "addi_pce");
      chk(c + 2, F_PC4E,     32'h104, "addi_pc4e");
      step();
      c = cyc; drive_f(I_ADD, 32'h104);
      chk(c + 2, F_RD1,     32'd0, "add_rd1_clear");
      chk(c + 2, F_RD2,     32'd0, "add_rd2_clear");
      chk(c + 2, F_ALUSRC,  32'd0, "add_alusrc");
      chk(c + 2, F_ILLEGAL, 32'd0, "add_illegal");
      step();

      // Bypass of x5 while sub sits in IF/ID, then normal read of the written value.
      c = cyc; drive_f(I_SUB, 32'h108);
      chk(c + 2, F_RD1,     32'hDEAD_BEEF, "bypass_rd1");
      chk(c + 2, F_ALUCTRL, 32'd1,         "sub_aluctrl");
      chk(c + 2, F_RDE,     32'd8,         "sub_rde");
      step();
      bus.RegWriteW = 1'b1; bus.RdW = 5'd5; bus.ResultW = 32'hDEAD_BEEF;
      c = cyc; drive_f(I_OR, 32'h10C);
      chk(c + 2, F_RD1,     32'hDEAD_BEEF, "or_rd1_written");
      chk(c + 2, F_ALUCTRL, 32'd3,         "or_aluctrl");
      step();
      bus.RegWriteW = 1'b0;

      // Writes to x0 are dropped and never bypassed.
      c = cyc; drive_f(I_AND, 32'h110);
      chk(c + 2, F_RD1,     32'd0,         "x0_no_bypass");
      chk(c + 2, F_RD2,     32'hDEAD_BEEF, "and_rd2");
      chk(c + 2, F_ALUCTRL, 32'd2,         "and_aluctrl");
      step();
      bus.RegWriteW = 1'b1; bus.RdW = 5'd0; bus.ResultW = 32'h0000_1234;
      c = cyc; drive_f(I_SLT, 32'h114);
      chk(c + 2, F_RD1,     32'd0, "x0_read_zero");
      chk(c + 2, F_ALUCTRL, 32'd5, "slt_aluctrl");
      step();
      bus.RegWriteW = 1'b0;

      c = cyc; drive_f(I_BEQ, 32'h118);
      chk(c + 2, F_BRANCH,   32'd1,         "beq_branch");
      chk(c + 2, F_ALUCTRL,  32'd1,         "beq_aluctrl");
      chk(c + 2, F_IMM,      32'hFFFF_FFFC, "beq_imm");
      chk(c + 2, F_REGWRITE, 32'd0,         "beq_regwrite");
      chk(c + 2, F_RDE,      32'd29,        "beq_rde");
      step();
      c = cyc; drive_f(I_SW, 32'h11C);
      chk(c + 2, F_MEMWRITE, 32'd1,         "sw_memwrite");
      chk(c + 2, F_IMM,      32'd8,         "sw_imm");
      chk(c + 2, F_REGWRITE, 32'd0,         "sw_regwrite");
      chk(c + 2, F_RD2,      32'hDEAD_BEEF, "sw_rd2");
      step();
      c = cyc; drive_f(I_LW, 32'h120);
      chk(c + 2, F_RESSRC, 32'd1,         "lw_ressrc");
      chk(c + 2, F_IMM,    32'hFFFF_FFFF, "lw_imm");
      chk(c + 2, F_ALUSRC, 32'd1,         "lw_alusrc");
      step();
      c = cyc; drive_f(I_JAL, 32'h124);
      chk(c + 2, F_JUMP,     32'd1, "jal_jump");
      chk(c + 2, F_RESSRC,   32'd2, "jal_ressrc");
      chk(c + 2, F_IMM,      32'd8, "jal_imm");
      chk(c + 2, F_REGWRITE, 32'd1, "jal_regwrite");
      step();
      c = cyc; drive_f(I_BAD, 32'h128);
      chk(c + 2, F_ILLEGAL,  32'd1, "badop_illegal");
      chk(c + 2, F_REGWRITE, 32'd0, "badop_regwrite");
      step();
      c = cyc; drive_f(I_SLL, 32'h12C);
      chk(c + 2, F_ILLEGAL, 32'd1, "sll_illegal");
      chk(c + 2, F_ALUCTRL, 32'd0, "sll_aluctrl");
      step();

      // Stall three cycles under FlushE, then StallD+FlushD together.
      c = cyc; drive_f(I_ADDI, 32'h200);
      step();
      bus.StallD = 1'b1; bus.FlushE = 1'b1; drive_f(I_BAD, 32'h300);
      for (int k = 2; k <= 4; k++) begin
         chk(c + k, F_REGWRITE, 32'd0, "flushe_regwrite");
         chk(c + k, F_PCE,      32'd0, "flushe_pce");
      end
      step(); step(); step();
      bus.StallD = 1'b0; bus.FlushE = 1'b0;
      chk(c + 5, F_PCE,      32'h200, "stall_held_pce");
      chk(c + 5, F_REGWRITE, 32'd1,   "stall_held_regwrite");
      chk(c + 5, F_IMM,      32'd7,   "stall_held_imm");
      step();
      bus.StallD = 1'b1; bus.FlushD = 1'b1; drive_f(I_SW, 32'h400);
      chk(c + 6, F_ILLEGAL, 32'd1,   "after_stall_illegal");
      chk(c + 6, F_PCE,     32'h300, "after_stall_pce");
      step();
      bus.StallD = 1'b0; bus.FlushD = 1'b0; drive_f(I_NOP, 32'h404);
      chk(c + 7, F_REGWRITE, 32'd1, "flushd_nop_regwrite");
      chk(c + 7, F_ALUSRC,   32'd1, "flushd_nop_alusrc");
      chk(c + 7, F_ILLEGAL,  32'd0, "flushd_nop_illegal");
      step();

      // Asynchronous reset in the middle of a stall.
      c = cyc; drive_f(I_OR, 32'h500);
      step();
      bus.StallD = 1'b1;
      step();
      rst = 1'b1;
      chk(c + 2, F_REGWRITE, 32'd0, "midrst_regwrite");
      chk(c + 2, F_ALUCTRL,  32'd0, "midrst_aluctrl");
      chk(c + 2, F_RD1,      32'd0, "midrst_rd1");
      chk(c + 2, F_RS1D,     32'd0, "midrst_rs1d");
      chk(c + 2, F_PCE,      32'd0, "midrst_pce");
      step();
      rst = 1'b0; bus.StallD = 1'b0;
      c = cyc; drive_f(I_OR, 32'h600);
      chk(c + 2, F_RD1,      32'd0,   "postrst_x5_clear");
      chk(c + 2, F_REGWRITE, 32'd1,   "postrst_regwrite");
      chk(c + 2, F_PCE,      32'h600, "postrst_pce");
      step();
      drive_f(I_NOP, 32'h604);
      repeat (3) step();

      done = 1'b1;
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
